// File: rtl/ftdi_rx.sv
// ftdi_rx: receiver for the FTDI fast serial (FSDO) link.
// Deserialises 10-bit frames (start 0, 8 data bits LSB first, source bit)
// into a small FIFO and raises fs_block when that FIFO is nearly full.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for a start bit (fsdo low)
// DATA  | shifting in the 8 data bits, LSB first
// SRC   | sampling the source bit and staging the push
//
// Ports:
//   clock      single clock, rising edge; fsdo is sampled on this edge
//   reset      synchronous, active-high reset
//   fsdo       serial data from the FTDI, idles high
//   fs_block   registered; high asks the top level to hold FSDI low
//   rx_data    byte at the FIFO head (0 while empty)
//   rx_channel source bit of the head frame (0 while empty)
//   rx_valid   FIFO holds at least one frame
//   rx_ready   consumer takes the head frame when high with rx_valid
//   overflow   sticky; a completed frame was dropped (cleared by reset)
//   state      FSM state for debug (IDLE=0, DATA=1, SRC=2)
module ftdi_rx #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fsdo,
  output logic       fs_block,
  output logic [7:0] rx_data,
  output logic       rx_channel,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overflow,
  output logic [1:0] state
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] BLOCK_C = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    SRC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        push_q;
  logic [8:0]  push_word;

  logic [8:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_next;
  logic        pop, full, wr_en;

  // ---------------- frame FSM ----------------
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = fsdo ? IDLE : DATA;
      DATA:    state_d = (bit_cnt == 3'd7) ? SRC : DATA;
      SRC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      push_q    <= 1'b0;
      push_word <= 9'h000;
    end else begin
      state_q <= state_d;
      push_q  <= 1'b0;
      case (state_q)
        IDLE: bit_cnt <= 3'd0;
        DATA: begin
          shreg[bit_cnt] <= fsdo;
          bit_cnt        <= bit_cnt + 3'd1;
        end
        SRC: begin
          // Staged one cycle so the FIFO write lands on the following edge.
          push_q    <= 1'b1;
          push_word <= {fsdo, shreg};
        end
        default: bit_cnt <= 3'd0;
      endcase
    end
  end

  assign state = state_q;

  // ---------------- frame FIFO ----------------
  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (count == FULL_C);
  // A pop on a full FIFO frees the head slot in the same edge.
  assign wr_en    = push_q && (!full || pop);

  always_comb begin
    count_next = count;
    case ({wr_en, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fs_block <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      // Asserted at DEPTH-1 so a frame already on the wire still fits.
      fs_block <= (count_next >= BLOCK_C);
      if (push_q && full && !pop) overflow <= 1'b1;
    end
  end

  assign rx_data    = rx_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign rx_channel = rx_valid ? mem[rd_ptr][8]   : 1'b0;

endmodule

// File: tb/tb_ftdi_rx.sv
// tb_ftdi_rx: directed self-checking bench for ftdi_rx (DEPTH=4).
module tb_ftdi_rx;

  logic       clock;
  logic       reset;
  logic       fsdo;
  logic       fs_block;
  logic [7:0] rx_data;
  logic       rx_channel;
  logic       rx_valid;
  logic       rx_ready;
  logic       overflow;
  logic [1:0] state;

  int vec_cnt = 0;
  int err_cnt = 0;

  ftdi_rx #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .fsdo       (fsdo),
    .fs_block   (fs_block),
    .rx_data    (rx_data),
    .rx_channel (rx_channel),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .overflow   (overflow),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_body(input logic [7:0] d, input logic s);
    for (int i = 0; i < 8; i++) begin
      fsdo = d[i];
      tick();
    end
    fsdo = s;
    tick();
    fsdo = 1'b1;
  endtask

  // Returns right after the SRC edge; the push lands on the next edge.
  task automatic send_frame(input logic [7:0] d, input logic s);
    fsdo = 1'b0;
    tick();
    send_body(d, s);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    fsdo  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; fsdo = 1'b1; rx_ready = 1'b0;
    tick(); tick();
    vec_cnt++; if (state !== 2'd0) begin err_cnt++; $display("FAIL reset_state: got %0d want 0", state); end
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    vec_cnt++; if (fs_block !== 1'b0) begin err_cnt++; $display("FAIL reset_fs_block: got %b want 0", fs_block); end
    vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_data: got %h want 00", rx_data); end
    vec_cnt++; if (rx_channel !== 1'b0) begin err_cnt++; $display("FAIL reset_channel: got %b want 0", rx_channel); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    send_frame(8'h4A, 1'b1);
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL single_latency: got %b want 0", rx_valid); end
    vec_cnt++; if (state !== 2'd0) begin err_cnt++; $display("FAIL single_idle_after_src: got %0d want 0", state); end
    tick();
    vec_cnt++; if (rx_valid !== 1'b1) begin err_cnt++; $display("FAIL single_valid: got %b want 1", rx_valid); end
    vec_cnt++; if (rx_data !== 8'h4A) begin err_cnt++; $display("FAIL single_data: got %h want 4a", rx_data); end
    vec_cnt++; if (rx_channel !== 1'b1) begin err_cnt++; $display("FAIL single_channel: got %b want 1", rx_channel); end
    rx_ready = 1'b1;
    tick();
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL single_pop: got %b want 0", rx_valid); end
    rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back_overflow();
    logic [7:0] exp_d [4];
    logic       exp_s [4];
    exp_d[0] = 8'h00; exp_s[0] = 1'b0;
    exp_d[1] = 8'hFF; exp_s[1] = 1'b1;
    exp_d[2] = 8'h55; exp_s[2] = 1'b0;
    exp_d[3] = 8'hA5; exp_s[3] = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], exp_s[i]);
    vec_cnt++; if (fs_block !== 1'b0) begin err_cnt++; $display("FAIL b2b_block_at_2: got %b want 0", fs_block); end
    fsdo = 1'b0;
    tick();
    vec_cnt++; if (fs_block !== 1'b1) begin err_cnt++; $display("FAIL b2b_block_at_3: got %b want 1", fs_block); end
    send_body(exp_d[3], exp_s[3]);
    tick();
    vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
    vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL b2b_head: got %h want 00", rx_data); end
    // fifth frame into a full FIFO with no consumer
    send_frame(8'h77, 1'b0);
    tick();
    vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_set: got %b want 1", overflow); end
    vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL ovf_head_kept: got %h want 00", rx_data); end
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (rx_valid !== 1'b1 || rx_data !== exp_d[i] || rx_channel !== exp_s[i]) begin
        err_cnt++;
        $display("FAIL b2b_read%0d: got v=%b d=%h c=%b want v=1 d=%h c=%b",
                 i, rx_valid, rx_data, rx_channel, exp_d[i], exp_s[i]);
      end
      tick();
    end
    rx_ready = 1'b0;
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_drained: got %b want 0", rx_valid); end
    vec_cnt++; if (fs_block !== 1'b0) begin err_cnt++; $display("FAIL b2b_unblock: got %b want 0", fs_block); end
    tick(); tick();
    vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_d [4];
    logic       exp_s [4];
    reset_dut();
    exp_d[0] = 8'h22; exp_s[0] = 1'b1;
    exp_d[1] = 8'h33; exp_s[1] = 1'b0;
    exp_d[2] = 8'h44; exp_s[2] = 1'b1;
    exp_d[3] = 8'h3C; exp_s[3] = 1'b0;
    send_frame(8'h11, 1'b0);
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], exp_s[i]);
    send_frame(8'h3C, 1'b0);
    rx_ready = 1'b1;
    tick();
    vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
    vec_cnt++; if (fs_block !== 1'b1) begin err_cnt++; $display("FAIL fpp_block: got %b want 1", fs_block); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (rx_valid !== 1'b1 || rx_data !== exp_d[i] || rx_channel !== exp_s[i]) begin
        err_cnt++;
        $display("FAIL fpp_read%0d: got v=%b d=%h c=%b want v=1 d=%h c=%b",
                 i, rx_valid, rx_data, rx_channel, exp_d[i], exp_s[i]);
      end
      tick();
    end
    rx_ready = 1'b0;
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL fpp_count4: got %b want 0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    fsdo = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      fsdo = 1'b1;
      tick();
    end
    fsdo  = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_no_push: got %b want 0", rx_valid); end
    vec_cnt++; if (state !== 2'd0) begin err_cnt++; $display("FAIL mid_state: got %0d want 0", state); end
    send_frame(8'h81, 1'b1);
    tick();
    vec_cnt++; if (rx_data !== 8'h81 || rx_channel !== 1'b1) begin err_cnt++; $display("FAIL mid_next_frame: got d=%h c=%b want d=81 c=1", rx_data, rx_channel); end
    // start bit held through reset release
    reset = 1'b1;
    fsdo  = 1'b0;
    tick();
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_clears_fifo: got %b want 0", rx_valid); end
    reset = 1'b0;
    tick();
    vec_cnt++; if (state !== 2'd1) begin err_cnt++; $display("FAIL rst_start_bit: got %0d want 1", state); end
    send_body(8'hC3, 1'b0);
    tick();
    vec_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3 || rx_channel !== 1'b0) begin err_cnt++; $display("FAIL rst_start_frame: got v=%b d=%h c=%b want v=1 d=c3 c=0", rx_valid, rx_data, rx_channel); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_ready_when_empty();
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL empty_ready%0d: got %b want 0", i, rx_valid); end
    end
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    tick();
    vec_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin err_cnt++; $display("FAIL empty_then_push: got v=%b d=%h want v=1 d=5a", rx_valid, rx_data); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL empty_single_pop: got %b want 0", rx_valid); end
  endtask

  task automatic test_idle();
    fsdo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      vec_cnt++;
      if (state !== 2'd0 || rx_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL idle_cycle%0d: got state=%0d v=%b want state=0 v=0", i, state, rx_valid);
      end
    end
  endtask

  initial begin
    reset = 1'b1; fsdo = 1'b1; rx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back_overflow();
    test_full_push_pop();
    test_reset_midframe();
    test_ready_when_empty();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
